// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: UART transmitter mapped onto the data-memory bus.
// Stores to TXDATA are queued in a byte FIFO. Each byte is sent as an 8N1 frame on tx.
// STATUS reports the FIFO level, the empty/full flags, transmitter activity and a sticky overflow bit.
module mmio_uart_tx #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0040
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        tx_busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    // Address decode. The block covers 8 bytes, and Address[2] selects the register.
    logic sel;
    logic off;
    logic wr_txdata;
    logic wr_status;
    logic unused_bits;

    assign sel         = (Address[31:3] == BASE_ADDR[31:3]);
    assign off         = Address[2];
    assign wr_txdata   = MemWrite & sel & ~off;
    assign wr_status   = MemWrite & sel & off;
    assign unused_bits = ^{WriteData[31:8], Address[1:0]};

    // FIFO storage and bookkeeping.
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // The full check uses the pre-edge level, so a pop on the same edge does not make room.
    assign push  = wr_txdata & ~full;

    // Serializer state.
    state_e           state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             expired;

    assign expired = (baud_q == '0);

    // FIFO next-state: pointers, occupancy and sticky overflow.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (wr_txdata && full) begin
            ovf_d = 1'b1;
        end else if (wr_status && WriteData[3]) begin
            ovf_d = 1'b0;
        end
    end

    // Frame FSM next-state. Every bit is held for CLK_DIV cycles by the baud down-counter.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem_q[head_q];
                    baud_d  = DIV_LOAD;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (expired) begin
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    baud_d  = DIV_LOAD;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (expired) begin
                    baud_d = DIV_LOAD;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            STOP: begin
                if (expired) begin
                    if (!empty) begin
                        // The next frame starts immediately, with no idle gap after the stop bit.
                        pop     = 1'b1;
                        shift_d = fifo_mem_q[head_q];
                        baud_d  = DIV_LOAD;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) | (count_d != '0);
    end

    // Register update for the FIFO control, the serializer and the outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // FIFO data array write.
    always_ff @(posedge clk) begin
        // NOTE: the data array is not reset. Only entries below count are ever read, so reset wiring is unnecessary.
        if (push) begin
            fifo_mem_q[tail_q] <= WriteData[7:0];
        end
    end

    // Combinational load data. Only a load to STATUS returns a nonzero value.
    logic [7:0] status_count;

    always_comb begin
        status_count               = '0;
        status_count[CNT_W-1:0]    = count_q;
        ReadData                   = '0;
        if (MemRead && !MemWrite && sel && off) begin
            ReadData = {16'b0, status_count, 4'b0, ovf_q, (state_q != IDLE), empty, full};
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and random bus traffic checked against a frame-schedule model.
// The model records, for each accepted byte, the edge at which it was stored and the edge at which its frame starts.
// The expected tx level, busy flag and STATUS word are derived from that schedule.
module tb_mmio_uart_tx;

    localparam int          DIV    = 4;
    localparam int          DEPTH  = 4;
    localparam int          FRAME  = 10 * DIV;
    localparam logic [31:0] BASE   = 32'h1001_0040;
    localparam logic [31:0] TXDATA = 32'h1001_0040;
    localparam logic [31:0] STATUS = 32'h1001_0044;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] ReadData;
    logic        tx;
    logic        tx_busy;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .CLK_DIV   (DIV),
        .FIFO_DEPTH(DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .ReadData (ReadData),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    // Reference schedule: one entry per accepted byte.
    int         m_push_edge[$];
    int         m_start[$];
    logic [7:0] m_data[$];
    logic       m_ovf = 1'b0;

    // Bytes queued (accepted but not yet started) after edge t.
    function automatic int model_count(input int t);
        int c = 0;
        foreach (m_start[i]) begin
            if (m_push_edge[i] <= t && m_start[i] > t) c++;
        end
        return c;
    endfunction

    function automatic logic model_active(input int t);
        foreach (m_start[i]) begin
            if (m_start[i] <= t && t < m_start[i] + FRAME) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Line level after edge t. Slot 0 is the start bit, slots 1..8 carry data LSB first, and slot 9 is the stop bit.
    function automatic logic model_tx(input int t);
        int b;
        logic [7:0] d;
        foreach (m_start[i]) begin
            if (m_start[i] <= t && t < m_start[i] + FRAME) begin
                b = (t - m_start[i]) / DIV;
                d = m_data[i];
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return d[b-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_status(input int t);
        int c;
        c = model_count(t);
        return {16'b0, 8'(c), 4'b0, m_ovf, model_active(t), (c == 0), (c == DEPTH)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed 0x%08h expected 0x%08h", tag, edge_no, obs, exp);
        end
    endtask

    // Advances one clock edge, updates the model with the inputs held across that edge, and checks tx and tx_busy.
    task automatic tick();
        int e, pre, last_end, s;
        @(posedge clk);
        edge_no++;
        e = edge_no;
        if (reset) begin
            m_push_edge.delete();
            m_start.delete();
            m_data.delete();
            m_ovf = 1'b0;
        end else if (MemWrite && (Address[31:3] == BASE[31:3])) begin
            if (!Address[2]) begin
                pre = model_count(e - 1);
                if (pre >= DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    last_end = (m_start.size() == 0) ? 0 : m_start[$] + FRAME;
                    s = (e + 1 > last_end) ? e + 1 : last_end;
                    m_push_edge.push_back(e);
                    m_start.push_back(s);
                    m_data.push_back(WriteData[7:0]);
                end
            end else if (WriteData[3]) begin
                m_ovf = 1'b0;
            end
        end
        #1;
        check("tx", 32'(tx), 32'(model_tx(e)));
        check("tx_busy", 32'(tx_busy), 32'(model_active(e) || (model_count(e) != 0)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sw(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic lw_check(input string tag, input logic [31:0] addr, input logic rd,
                            input logic [31:0] exp);
        Address = addr;
        MemRead = rd;
        #1;
        check(tag, ReadData, exp);
        MemRead = 1'b0;
    endtask

    initial begin
        // 1: reset state.
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        lw_check("reset_status", STATUS, 1'b1, 32'h0000_0002);
        lw_check("reset_status_model", STATUS, 1'b1, model_status(edge_no));

        // 2: single byte, full frame shape.
        sw(TXDATA, 32'h0000_00A5);
        lw_check("txdata_reads_zero", TXDATA, 1'b1, 32'h0);
        idle(3);
        lw_check("single_status", STATUS, 1'b1, model_status(edge_no));
        idle(42);
        lw_check("single_done", STATUS, 1'b1, 32'h0000_0002);

        // 3: back-to-back frames with no idle gap between them.
        sw(TXDATA, 32'h0000_0055);
        sw(TXDATA, 32'h0000_000F);
        lw_check("b2b_status", STATUS, 1'b1, model_status(edge_no));
        idle(85);

        // 4: overflow. One byte is in flight, four are queued, and the sixth is dropped.
        for (int i = 0; i < 6; i++) sw(TXDATA, 32'($urandom_range(0, 255)));
        lw_check("ovf_status_model", STATUS, 1'b1, model_status(edge_no));
        lw_check("ovf_status", STATUS, 1'b1, 32'h0000_040D);
        sw(STATUS, 32'h0000_0008);
        lw_check("ovf_cleared", STATUS, 1'b1, model_status(edge_no));
        idle(5 * FRAME + 5);

        // 5: reset asserted mid-frame while two bytes are still queued.
        for (int i = 0; i < 3; i++) sw(TXDATA, 32'($urandom_range(0, 255)));
        idle(8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lw_check("midreset_status", STATUS, 1'b1, 32'h0000_0002);
        idle(60);
        lw_check("midreset_quiet", STATUS, 1'b1, model_status(edge_no));

        // 6: decode. Stores outside the window are ignored, loads need MemRead, and Address[1:0] is ignored.
        sw(32'h1001_0048, 32'h0000_00C3);
        idle(2);
        lw_check("decode_nopush", STATUS, 1'b1, 32'h0000_0002);
        lw_check("decode_noread", STATUS, 1'b0, 32'h0);
        lw_check("decode_outside", 32'h1001_0048, 1'b1, 32'h0);
        lw_check("decode_lowbits", 32'h1001_0047, 1'b1, model_status(edge_no));

        // Random traffic: bursts of stores, idle gaps, overflow clears and status polls.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0: sw(STATUS, 32'($urandom_range(0, 15)));
                1, 2: idle($urandom_range(1, 30));
                default: sw(TXDATA, $urandom);
            endcase
            lw_check("rand_status", STATUS, 1'b1, model_status(edge_no));
        end
        idle(DEPTH * FRAME + FRAME + 5);
        lw_check("drain_status", STATUS, 1'b1, model_status(edge_no));
        lw_check("drain_empty", STATUS, 1'b1, {28'b0, m_ovf, 3'b010});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
